e203_exu_oitf_trk: RTL and testbench
====================================

// Module: e203_exu_oitf_trk
// PURPOSE
//  Outstanding-instruction tracking FIFO: the producer of oitf_empty/oitf_ret_ptr
//  and the consumer of oitf_ret_ena for the EXU write-back stages.
//  Dispatch allocates an entry (itag) for each long/deferred instruction.
//  Write-back retires the head entry in order.
//  Also flags RAW/WAW hazards of the dispatching instruction against all outstanding rd.
// PARAMETERS
//  DEPTH        2   entries, power of two, >=2
//  ITAG_WIDTH   1   log2(DEPTH); width of dis_ptr/oitf_ret_ptr
//  RFIDX_WIDTH  5   register index width
//  PC_SIZE      32  PC width stored per entry
// PORTS
//  clk                  in   1            single clock, rising edge
//  rst                  in   1            synchronous, active-high reset
//  dis_ena              in   1            allocate request (dispatch fires)
//  dis_ready            out  1            ~oitf_full
//  disp_i_rdwen         in   1            instruction writes rd
//  disp_i_rdidx         in   RFIDX_WIDTH  rd index to record and hazard-check
//  disp_i_pc            in   PC_SIZE      PC to record
//  disp_i_rs1en         in   1            rs1 used
//  disp_i_rs2en         in   1            rs2 used
//  disp_i_rs1idx        in   RFIDX_WIDTH  rs1 index
//  disp_i_rs2idx        in   RFIDX_WIDTH  rs2 index
//  dis_ptr              out  ITAG_WIDTH   itag granted to the current allocation (= alloc ptr)
//  oitf_ret_ena         in   1            retire head entry (from write-back)
//  oitf_ret_ptr         out  ITAG_WIDTH   itag of head entry
//  oitf_ret_rdidx       out  RFIDX_WIDTH  head rd index
//  oitf_ret_rdwen       out  1            head rdwen
//  oitf_ret_pc          out  PC_SIZE      head PC
//  oitf_empty           out  1            no outstanding entries
//  oitf_full            out  1            DEPTH outstanding entries
//  oitfrd_match_disprs1 out  1            rs1 RAW hazard
//  oitfrd_match_disprs2 out  1            rs2 RAW hazard
//  oitfrd_match_disprd  out  1            rd WAW hazard
// BEHAVIOUR
//  State: alloc_ptr/ret_ptr (ITAG_WIDTH) each with a wrap flag; per entry valid, rdwen, rdidx, pc.
//  Reset (rst=1 at edge): pointers, flags, valids and entry fields all 0.
//   Outputs after reset: oitf_empty=1, oitf_full=0, dis_ready=1, dis_ptr=0, oitf_ret_ptr=0,
//   ret fields 0, match outputs 0.
//   rst asserted mid-operation discards all entries the same edge.
//  alloc = dis_ena & ~oitf_full. On the edge: entry[alloc_ptr] <= {1, rdwen, rdidx, pc};
//   alloc_ptr+1. At DEPTH-1, alloc_ptr wraps to 0 and toggles the alloc flag.
//  ret = oitf_ret_ena & ~oitf_empty. On the edge: entry[ret_ptr].valid <= 0; ret_ptr+1,
//   with the same wrap rule. oitf_ret_ena while empty is ignored (no state change).
//  oitf_empty = (alloc_ptr==ret_ptr) & (flags equal). oitf_full = ptrs equal & flags differ.
//   Both are pure functions of registered state.
//  Simultaneous alloc+ret: both take effect. When full, alloc is blocked this cycle even if
//   ret fires; the slot frees next cycle. When empty, ret is ignored and alloc proceeds.
//  dis_ptr = alloc_ptr, combinational. Valid in the same cycle as dis_ena; consumers capture
//   it as the itag.
//  oitf_ret_* = fields of entry[ret_ptr], combinational from registers. Latency 0 from state.
//   Undefined-but-stable (last written) when empty.
//  Hazards: OR over entries with valid & rdwen:
//   rs1: disp_i_rs1en & (rdidx==rs1idx); rs2 likewise; rd: disp_i_rdwen & (rdidx==disp_i_rdidx).
//   Index 0 is not special-cased.
//   Hazards reflect state before the current cycle's alloc/ret (no bypass of the retiring entry).
//  No pipelining: every update completes in one edge. Occupancy never exceeds DEPTH.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> empty=1, full=0, dis_ready=1, dis_ptr=0, ret_ptr=0, all matches 0.
//  T2 fill/drain DEPTH=2: alloc rd=5 pc=0x100, then rd=6 pc=0x104 -> full=1, dis_ready=0,
//   ret_rdidx=5, ret_pc=0x100; ret twice -> ret_ptr 0->1->0, empty=1.
//  T3 wrap: 5 alloc/ret pairs one cycle apart -> dis_ptr sequence 0,1,0,1,0;
//   empty/full never asserted incorrectly.
//  T4 simultaneous: 1 entry outstanding, dis_ena+ret_ena same cycle -> occupancy stays 1,
//   ret_ptr and alloc_ptr both advance. When full, same stimulus -> only ret; occupancy 1.
//  T5 hazard: outstanding rd=7 rdwen=1; dispatch rs1en=1 rs1idx=7, rs2idx=3 -> match_rs1=1,
//   match_rs2=0. After its ret edge -> match_rs1=0. Same entry with rdwen=0 -> no matches.
//  T6 illegal/edge: ret_ena while empty -> no change. rst asserted while full -> next cycle
//   empty=1 and hazard outputs 0.

Source files
------------

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding-instruction tracking FIFO for the EXU: allocates itags at dispatch,
// retires them in order at write-back, and flags RAW/WAW hazards against outstanding rd.
module e203_exu_oitf_trk #(
    parameter int DEPTH       = 2,
    parameter int ITAG_WIDTH  = 1,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dis_ena,
    output logic                   dis_ready,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
    output logic [ITAG_WIDTH-1:0]  dis_ptr,
    input  logic                   oitf_ret_ena,
    output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
    output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
    output logic                   oitf_ret_rdwen,
    output logic [PC_SIZE-1:0]     oitf_ret_pc,
    output logic                   oitf_empty,
    output logic                   oitf_full,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd
);

    localparam logic [ITAG_WIDTH-1:0] LAST = ITAG_WIDTH'(DEPTH - 1);

    logic [ITAG_WIDTH-1:0]  alloc_ptr;
    logic [ITAG_WIDTH-1:0]  ret_ptr;
    logic                   alloc_flg;
    logic                   ret_flg;
    logic                   vld      [DEPTH];
    logic                   rdwen_r  [DEPTH];
    logic [RFIDX_WIDTH-1:0] rdidx_r  [DEPTH];
    logic [PC_SIZE-1:0]     pc_r     [DEPTH];

    logic alloc;
    logic ret;

    // Wrap flags disambiguate full from empty when the pointers coincide.
    assign oitf_empty = (alloc_ptr == ret_ptr) & (alloc_flg == ret_flg);
    assign oitf_full  = (alloc_ptr == ret_ptr) & (alloc_flg != ret_flg);
    assign dis_ready  = ~oitf_full;
    assign alloc      = dis_ena & ~oitf_full;
    assign ret        = oitf_ret_ena & ~oitf_empty;

    assign dis_ptr        = alloc_ptr;
    assign oitf_ret_ptr   = ret_ptr;
    assign oitf_ret_rdidx = rdidx_r[ret_ptr];
    assign oitf_ret_rdwen = rdwen_r[ret_ptr];
    assign oitf_ret_pc    = pc_r[ret_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            ret_ptr   <= '0;
            alloc_flg <= 1'b0;
            ret_flg   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                vld[i]     <= 1'b0;
                rdwen_r[i] <= 1'b0;
                rdidx_r[i] <= '0;
                pc_r[i]    <= '0;
            end
        end else begin
            if (alloc) begin
                vld[alloc_ptr]     <= 1'b1;
                rdwen_r[alloc_ptr] <= disp_i_rdwen;
                rdidx_r[alloc_ptr] <= disp_i_rdidx;
                pc_r[alloc_ptr]    <= disp_i_pc;
                if (alloc_ptr == LAST) begin
                    alloc_ptr <= '0;
                    alloc_flg <= ~alloc_flg;
                end else begin
                    alloc_ptr <= alloc_ptr + 1'b1;
                end
            end
            // Alloc and ret never target the same slot: equal pointers imply empty or full.
            if (ret) begin
                vld[ret_ptr] <= 1'b0;
                if (ret_ptr == LAST) begin
                    ret_ptr <= '0;
                    ret_flg <= ~ret_flg;
                end else begin
                    ret_ptr <= ret_ptr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] & rdwen_r[i]) begin
                if (disp_i_rs1en & (rdidx_r[i] == disp_i_rs1idx)) oitfrd_match_disprs1 = 1'b1;
                if (disp_i_rs2en & (rdidx_r[i] == disp_i_rs2idx)) oitfrd_match_disprs2 = 1'b1;
                if (disp_i_rdwen & (rdidx_r[i] == disp_i_rdidx))  oitfrd_match_disprd  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Bench for e203_exu_oitf_trk: directed scenarios plus random traffic against a queue model.
module tb_e203_exu_oitf_trk;

    localparam int DEPTH = 2;
    localparam int IW    = 1;
    localparam int RW    = 5;
    localparam int PW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dis_ena = 1'b0;
    logic          dis_ready;
    logic          disp_i_rdwen = 1'b0;
    logic [RW-1:0] disp_i_rdidx = '0;
    logic [PW-1:0] disp_i_pc = '0;
    logic          disp_i_rs1en = 1'b0;
    logic          disp_i_rs2en = 1'b0;
    logic [RW-1:0] disp_i_rs1idx = '0;
    logic [RW-1:0] disp_i_rs2idx = '0;
    logic [IW-1:0] dis_ptr;
    logic          oitf_ret_ena = 1'b0;
    logic [IW-1:0] oitf_ret_ptr;
    logic [RW-1:0] oitf_ret_rdidx;
    logic          oitf_ret_rdwen;
    logic [PW-1:0] oitf_ret_pc;
    logic          oitf_empty;
    logic          oitf_full;
    logic          m_rs1, m_rs2, m_rd;

    e203_exu_oitf_trk #(.DEPTH(DEPTH), .ITAG_WIDTH(IW), .RFIDX_WIDTH(RW), .PC_SIZE(PW)) dut (
        .clk(clk), .rst(rst), .dis_ena(dis_ena), .dis_ready(dis_ready),
        .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
        .dis_ptr(dis_ptr), .oitf_ret_ena(oitf_ret_ena), .oitf_ret_ptr(oitf_ret_ptr),
        .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_pc(oitf_ret_pc),
        .oitf_empty(oitf_empty), .oitf_full(oitf_full),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2), .oitfrd_match_disprd(m_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rdwen;
        logic [RW-1:0] rdidx;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_alloc = 0;
    int   n_ret   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [IW-1:0] obs_dis_ptr;
    logic          obs_rs1, obs_rs2, obs_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the current cycle.
    task automatic check_all();
        logic e_rs1, e_rs2, e_rd;
        e_rs1 = 1'b0; e_rs2 = 1'b0; e_rd = 1'b0;
        foreach (q[i]) begin
            if (q[i].rdwen) begin
                if (disp_i_rs1en && q[i].rdidx == disp_i_rs1idx) e_rs1 = 1'b1;
                if (disp_i_rs2en && q[i].rdidx == disp_i_rs2idx) e_rs2 = 1'b1;
                if (disp_i_rdwen && q[i].rdidx == disp_i_rdidx)  e_rd  = 1'b1;
            end
        end
        check("empty", 64'(oitf_empty), 64'(q.size() == 0));
        check("full", 64'(oitf_full), 64'(q.size() == DEPTH));
        check("dis_ready", 64'(dis_ready), 64'(q.size() != DEPTH));
        check("dis_ptr", 64'(dis_ptr), 64'(n_alloc % DEPTH));
        check("ret_ptr", 64'(oitf_ret_ptr), 64'(n_ret % DEPTH));
        if (q.size() != 0) begin
            check("ret_rdwen", 64'(oitf_ret_rdwen), 64'(q[0].rdwen));
            check("ret_rdidx", 64'(oitf_ret_rdidx), 64'(q[0].rdidx));
            check("ret_pc", 64'(oitf_ret_pc), 64'(q[0].pc));
        end
        check("match_rs1", 64'(m_rs1), 64'(e_rs1));
        check("match_rs2", 64'(m_rs2), 64'(e_rs2));
        check("match_rd", 64'(m_rd), 64'(e_rd));
        obs_dis_ptr = dis_ptr;
        obs_rs1 = m_rs1; obs_rs2 = m_rs2; obs_rd = m_rd;
    endtask

    task automatic step(input logic r, input logic dis, input logic rdwen, input logic [RW-1:0] rdidx,
                        input logic [PW-1:0] pc, input logic rs1en, input logic [RW-1:0] rs1idx,
                        input logic rs2en, input logic [RW-1:0] rs2idx, input logic reten);
        logic do_alloc, do_ret;
        @(negedge clk);
        rst = r; dis_ena = dis; disp_i_rdwen = rdwen; disp_i_rdidx = rdidx; disp_i_pc = pc;
        disp_i_rs1en = rs1en; disp_i_rs1idx = rs1idx; disp_i_rs2en = rs2en; disp_i_rs2idx = rs2idx;
        oitf_ret_ena = reten;
        #1;
        check_all();
        @(posedge clk);
        if (r) begin
            q.delete();
            n_alloc = 0;
            n_ret = 0;
        end else begin
            do_alloc = dis && q.size() < DEPTH;
            do_ret   = reten && q.size() > 0;
            if (do_ret) begin
                void'(q.pop_front());
                n_ret++;
            end
            if (do_alloc) begin
                q.push_back('{rdwen: rdwen, rdidx: rdidx, pc: pc});
                n_alloc++;
            end
        end
        #1;
        rst = 1'b0; dis_ena = 1'b0; oitf_ret_ena = 1'b0;
        disp_i_rdwen = 1'b0; disp_i_rs1en = 1'b0; disp_i_rs2en = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_alloc(input logic rdwen, input logic [RW-1:0] rdidx, input logic [PW-1:0] pc);
        step(1'b0, 1'b1, rdwen, rdidx, pc, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_ret();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Idle cycle with all enables low; checks state-only outputs against constants.
    task automatic probe(input logic e_empty, input logic e_full, input logic [IW-1:0] e_ret_ptr);
        @(negedge clk);
        #1;
        check_all();
        check("probe_empty", 64'(oitf_empty), 64'(e_empty));
        check("probe_full", 64'(oitf_full), 64'(e_full));
        check("probe_ret_ptr", 64'(oitf_ret_ptr), 64'(e_ret_ptr));
    endtask

    initial begin
        // T1: reset held two cycles
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        do_reset();
        probe(1'b1, 1'b0, 1'b0);
        check("t1_dis_ptr", 64'(dis_ptr), 64'd0);
        check("t1_ret_pc", 64'(oitf_ret_pc), 64'd0);
        check("t1_ret_rdidx", 64'(oitf_ret_rdidx), 64'd0);
        check("t1_matches", 64'({m_rs1, m_rs2, m_rd}), 64'd0);

        // T2: fill then drain
        do_alloc(1'b1, 5'd5, 32'h100);
        do_alloc(1'b1, 5'd6, 32'h104);
        probe(1'b0, 1'b1, 1'b0);
        check("t2_dis_ready", 64'(dis_ready), 64'd0);
        check("t2_ret_rdidx", 64'(oitf_ret_rdidx), 64'd5);
        check("t2_ret_pc", 64'(oitf_ret_pc), 64'h100);
        do_ret();
        probe(1'b0, 1'b0, 1'b1);
        check("t2_ret_pc2", 64'(oitf_ret_pc), 64'h104);
        do_ret();
        probe(1'b1, 1'b0, 1'b0);

        // T3: alloc/ret pairs walk the pointers through wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_alloc(1'b1, 5'(i + 1), 32'(32'h200 + 4 * i));
            check("t3_dis_ptr", 64'(obs_dis_ptr), 64'(i % 2));
            do_ret();
        end
        probe(1'b1, 1'b0, 1'b1);

        // T4: simultaneous alloc+ret with one entry, then while full
        do_reset();
        do_alloc(1'b1, 5'd9, 32'h300);
        step(1'b0, 1'b1, 1'b1, 5'd10, 32'h304, 1'b0, '0, 1'b0, '0, 1'b1);
        probe(1'b0, 1'b0, 1'b1);
        check("t4_dis_ptr", 64'(dis_ptr), 64'd0);
        do_alloc(1'b1, 5'd11, 32'h308);
        probe(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5'd12, 32'h30c, 1'b0, '0, 1'b0, '0, 1'b1);
        probe(1'b0, 1'b0, 1'b0);
        check("t4_full_ret_pc", 64'(oitf_ret_pc), 64'h308);

        // T5: RAW hazard visible until the retire edge, none for rdwen=0
        do_reset();
        do_alloc(1'b1, 5'd7, 32'h400);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1);
        check("t5_rs1_hit", 64'(obs_rs1), 64'd1);
        check("t5_rs2_miss", 64'(obs_rs2), 64'd0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, 1'b0);
        check("t5_rs1_after_ret", 64'(obs_rs1), 64'd0);
        do_alloc(1'b0, 5'd7, 32'h404);
        step(1'b0, 1'b0, 1'b1, 5'd7, '0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
        check("t5_nowen", 64'({obs_rs1, obs_rs2, obs_rd}), 64'd0);

        // T6: retire while empty, then reset while full
        do_reset();
        do_ret();
        probe(1'b1, 1'b0, 1'b0);
        check("t6_dis_ptr", 64'(dis_ptr), 64'd0);
        do_alloc(1'b1, 5'd4, 32'h500);
        do_alloc(1'b1, 5'd4, 32'h504);
        step(1'b1, 1'b0, 1'b1, 5'd4, '0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0);
        check("t6_full_hit", 64'({obs_rs1, obs_rs2, obs_rd}), 64'h7);
        step(1'b0, 1'b0, 1'b1, 5'd4, '0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0);
        check("t6_rst_matches", 64'({obs_rs1, obs_rs2, obs_rd}), 64'd0);
        probe(1'b1, 1'b0, 1'b0);

        // Random traffic over a small register range so hazards actually occur
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 $urandom, 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
